// File: rtl/y86_pkg.sv
// Shared y86 encodings and types for the execute-stage condition logic.
package y86_pkg;

    // Instruction codes used by the execute stage
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Condition selects carried in ifun for jXX/cmovXX
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Architectural condition codes
    typedef struct packed {
        logic of;
        logic zf;
        logic sf;
    } cc_t;

    localparam cc_t CC_RESET = '{of: 1'b0, zf: 1'b1, sf: 1'b0};

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from the CC flags.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       of,
    input  logic       zf,
    input  logic       sf,
    output logic       cnd
);

    logic lt;

    // Decode the condition select against the flags; unused selects never fire
    always_comb begin
        lt  = sf ^ of;
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_cond_stage.sv
// Execute-stage CC register, condition evaluation, cmov dstE nulling and E->M register.
module cc_cond_stage
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_of,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic [WIDTH-1:0] e_valA,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             m_exc,
    input  logic             w_exc,
    input  logic             m_stall,
    input  logic             m_bubble,
    output logic             cc_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             e_cnd,
    output logic             M_valid,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    cc_t              cc_q, cc_d;
    logic             set_cc;
    logic [3:0]       e_dste_final;

    logic             m_valid_q, m_valid_d;
    logic [3:0]       m_icode_q, m_icode_d;
    logic             m_cnd_q, m_cnd_d;
    logic [WIDTH-1:0] m_vale_q, m_vale_d;
    logic [WIDTH-1:0] m_vala_q, m_vala_d;
    logic [3:0]       m_dste_q, m_dste_d;
    logic [3:0]       m_dstm_q, m_dstm_d;

    // Condition is always evaluated on the registered CC, never the live ALU flags
    cond_eval u_cond_eval (
        .ifun (e_ifun),
        .of   (cc_q.of),
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .cnd  (e_cnd)
    );

    // CC write: only a real OPq with no younger-stage exception commits its flags
    always_comb begin
        set_cc = e_valid & (e_icode == IOPQ) & ~m_exc & ~w_exc;
        cc_d   = cc_q;
        if (set_cc) begin
            cc_d = '{of: alu_of, zf: alu_zf, sf: alu_sf};
        end
    end

    // CC flops ignore stall/bubble so the committed OPq is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    // A cmov whose condition fails writes nothing
    always_comb begin
        e_dste_final = ((e_icode == IRRMOVQ) && !e_cnd) ? RNONE : e_dstE;
    end

    // E->M next state: bubble beats stall; an empty E slot loads a NOP
    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (m_bubble || (!m_stall && !e_valid)) begin
            m_valid_d = 1'b0;
            m_icode_d = INOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = RNONE;
            m_dstm_d  = RNONE;
        end else if (!m_stall) begin
            m_valid_d = 1'b1;
            m_icode_d = e_icode;
            m_cnd_d   = e_cnd;
            m_vale_d  = alu_y;
            m_vala_d  = e_valA;
            m_dste_d  = e_dste_final;
            m_dstm_d  = e_dstM;
        end
    end

    // E->M pipeline register with synchronous reset to NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_icode_q <= INOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= RNONE;
            m_dstm_q  <= RNONE;
        end else begin
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc_of   = cc_q.of;
    assign cc_zf   = cc_q.zf;
    assign cc_sf   = cc_q.sf;
    assign M_valid = m_valid_q;
    assign M_icode = m_icode_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule

// File: tb/tb_cc_cond_stage.sv
// Scoreboard bench for cc_cond_stage: directed cases then random traffic vs a reference model.
module tb_cc_cond_stage;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             e_valid = 1'b0;
    logic [3:0]       e_icode = 4'h1;
    logic [3:0]       e_ifun = 4'h0;
    logic [WIDTH-1:0] alu_y = '0;
    logic             alu_of = 1'b0;
    logic             alu_zf = 1'b0;
    logic             alu_sf = 1'b0;
    logic [WIDTH-1:0] e_valA = '0;
    logic [3:0]       e_dstE = 4'hF;
    logic [3:0]       e_dstM = 4'hF;
    logic             m_exc = 1'b0;
    logic             w_exc = 1'b0;
    logic             m_stall = 1'b0;
    logic             m_bubble = 1'b0;
    logic             cc_of, cc_zf, cc_sf, e_cnd;
    logic             M_valid, M_cnd;
    logic [3:0]       M_icode, M_dstE, M_dstM;
    logic [WIDTH-1:0] M_valE, M_valA;

    cc_cond_stage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_icode  (e_icode),
        .e_ifun   (e_ifun),
        .alu_y    (alu_y),
        .alu_of   (alu_of),
        .alu_zf   (alu_zf),
        .alu_sf   (alu_sf),
        .e_valA   (e_valA),
        .e_dstE   (e_dstE),
        .e_dstM   (e_dstM),
        .m_exc    (m_exc),
        .w_exc    (w_exc),
        .m_stall  (m_stall),
        .m_bubble (m_bubble),
        .cc_of    (cc_of),
        .cc_zf    (cc_zf),
        .cc_sf    (cc_sf),
        .e_cnd    (e_cnd),
        .M_valid  (M_valid),
        .M_icode  (M_icode),
        .M_cnd    (M_cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_dstE   (M_dstE),
        .M_dstM   (M_dstM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] vale;
        logic [WIDTH-1:0] vala;
        logic [3:0]       dste;
        logic [3:0]       dstm;
        logic             of;
        logic             zf;
        logic             sf;
    } exp_t;

    exp_t mq[$];
    logic cq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: the architectural flags and the last M contents
    logic mod_of = 1'b0, mod_zf = 1'b1, mod_sf = 1'b0;
    exp_t mod_m;

    function automatic exp_t nop_m();
        exp_t n;
        n.valid = 1'b0; n.icode = 4'd1; n.cnd = 1'b0; n.vale = '0; n.vala = '0;
        n.dste = 4'hF; n.dstm = 4'hF; n.of = 1'b0; n.zf = 1'b0; n.sf = 1'b0;
        return n;
    endfunction

    // Branch/cmov predicate in terms of "signed less-than" and "equal"
    function automatic logic model_cnd(input logic [3:0] f, input logic of, zf, sf);
        logic less, equal;
        less  = (sf != of);
        equal = zf;
        if (f == 4'd0) return 1'b1;
        if (f == 4'd1) return less || equal;
        if (f == 4'd2) return less;
        if (f == 4'd3) return equal;
        if (f == 4'd4) return !equal;
        if (f == 4'd5) return !less;
        if (f == 4'd6) return !less && !equal;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs and push what the model expects
    task automatic drive(input logic rst, v, input logic [3:0] ic, fn,
                         input logic [WIDTH-1:0] y, input logic of, zf, sf,
                         input logic [WIDTH-1:0] va, input logic [3:0] de, dm,
                         input logic mx, wx, st, bb);
        logic c;
        exp_t e;
        @(posedge clk);
        #3;
        reset = rst; e_valid = v; e_icode = ic; e_ifun = fn; alu_y = y;
        alu_of = of; alu_zf = zf; alu_sf = sf; e_valA = va; e_dstE = de; e_dstM = dm;
        m_exc = mx; w_exc = wx; m_stall = st; m_bubble = bb;

        c = model_cnd(fn, mod_of, mod_zf, mod_sf);
        cq.push_back(c);

        if (rst) begin
            mod_of = 1'b0; mod_zf = 1'b1; mod_sf = 1'b0;
            mod_m  = nop_m();
        end else begin
            if (v && ic == 4'd6 && !mx && !wx) begin
                mod_of = of; mod_zf = zf; mod_sf = sf;
            end
            if (bb || (!st && !v)) begin
                mod_m = nop_m();
            end else if (!st) begin
                mod_m.valid = 1'b1; mod_m.icode = ic; mod_m.cnd = c;
                mod_m.vale = y; mod_m.vala = va; mod_m.dstm = dm;
                mod_m.dste = (ic == 4'd2 && !c) ? 4'hF : de;
            end
        end
        e = mod_m;
        e.of = mod_of; e.zf = mod_zf; e.sf = mod_sf;
        mq.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd1, 4'd0, '0, 1'b0, 1'b0, 1'b0, '0, 4'hF, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: combinational cnd mid-cycle, registered state just after each edge
    initial begin
        exp_t e;
        logic c;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("e_cnd", {63'b0, e_cnd}, {63'b0, c});
            end
            @(posedge clk);
            #1;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                check("cc_of",   {63'b0, cc_of},   {63'b0, e.of});
                check("cc_zf",   {63'b0, cc_zf},   {63'b0, e.zf});
                check("cc_sf",   {63'b0, cc_sf},   {63'b0, e.sf});
                check("M_valid", {63'b0, M_valid}, {63'b0, e.valid});
                check("M_icode", {60'b0, M_icode}, {60'b0, e.icode});
                check("M_cnd",   {63'b0, M_cnd},   {63'b0, e.cnd});
                check("M_valE",  M_valE,           e.vale);
                check("M_valA",  M_valA,           e.vala);
                check("M_dstE",  {60'b0, M_dstE},  {60'b0, e.dste});
                check("M_dstM",  {60'b0, M_dstM},  {60'b0, e.dstm});
            end
        end
    end

    initial begin
        logic [3:0] ic, fn;
        mod_m = nop_m();

        // Reset, then idle
        drive(1'b1, 1'b0, 4'd1, 4'd0, '0, 1'b0, 1'b0, 1'b0, '0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        // OPq with zero result
        drive(1'b0, 1'b1, 4'd6, 4'd0, '0, 1'b0, 1'b1, 1'b0, 64'h5, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load negative CC, then cmovle (taken) and cmovge (not taken)
        drive(1'b0, 1'b1, 4'd6, 4'd1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b1, '0, 4'h1, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd2, 4'd1, 64'h1234, 1'b0, 1'b0, 1'b0, 64'h1234, 4'h3, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd2, 4'd5, 64'h5678, 1'b0, 1'b0, 1'b0, 64'h5678, 4'h3, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0);
        // OPq with exception: CC must not change, but the OPq still reaches M
        drive(1'b0, 1'b1, 4'd6, 4'd0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h9, 4'h4, 4'hF,
              1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd6, 4'd0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h9, 4'h4, 4'hF,
              1'b0, 1'b1, 1'b0, 1'b0);
        // Stall two cycles, then stall+bubble, then reset during stall
        drive(1'b0, 1'b1, 4'd7, 4'd3, 64'hAB, 1'b0, 1'b0, 1'b0, 64'hCD, 4'hF, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd7, 4'd4, 64'h11, 1'b0, 1'b0, 1'b0, 64'h22, 4'h5, 4'h6,
              1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd7, 4'd4, 64'h11, 1'b0, 1'b0, 1'b0, 64'h22, 4'h5, 4'h6,
              1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd7, 4'd4, 64'h11, 1'b0, 1'b0, 1'b0, 64'h22, 4'h5, 4'h6,
              1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd6, 4'd0, 64'h77, 1'b1, 1'b0, 1'b1, 64'h88, 4'h2, 4'h3,
              1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd6, 4'd0, 64'h77, 1'b1, 1'b0, 1'b1, 64'h88, 4'h2, 4'h3,
              1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Random traffic with biased icodes and occasional hazards
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    ic = 4'd6;
                2:       ic = 4'd2;
                3:       ic = 4'd7;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) != 0), ic, fn,
                  {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        idle();

        @(posedge clk);
        #5;
        n_cmp++;
        if (mq.size() != 0 || cq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", mq.size(), cq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
